ledpanel_fb_sched: RTL and testbench

Frame-buffer write scheduler for the 32x32 LED panel driver. Shares the panel's single video-memory write port between the CPU control bus and a streaming blitter. Double-buffers video memory (two 1024-pixel pages) and flips the displayed page only on a frame boundary reported by the scan engine. Sits between the icosoc bus/blitter and the panel scan module.

---
 rtl/ledpanel_pkg.sv | 19 +
 rtl/ledpanel_rgb_quant.sv | 25 ++
 rtl/ledpanel_fb_sched.sv | 131 +++++++++++++
 tb/tb_ledpanel_fb_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledpanel_pkg.sv
// Shared types and constants for the LED panel frame-buffer scheduler.
package ledpanel_pkg;

  localparam int unsigned LP_PIX_AW        = 10;
  localparam logic [15:0] LP_CTRL_ADDR     = 16'h1000;
  localparam logic [15:0] LP_FRAMECNT_ADDR = 16'h1004;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } lp_rgb444_t;

  typedef enum logic {
    LP_GNT_CPU,
    LP_GNT_BLIT
  } lp_gnt_e;

endpackage

// File: rtl/ledpanel_rgb_quant.sv
// RGB888 -> RGB444 converter; LEDPANEL_GAMMA_EN selects a squared (gamma ~2) curve.
module ledpanel_rgb_quant
  import ledpanel_pkg::*;
(
  input  logic [23:0] i_rgb,
  output lp_rgb444_t  o_rgb
);

  function automatic logic [3:0] quant(input logic [7:0] c);
`ifdef LEDPANEL_GAMMA_EN
    logic [15:0] p;
    p = 16'(c) * 16'(c);
    return p[15:12];
`else
    return c[7:4];
`endif
  endfunction

  always_comb begin
    o_rgb.r = quant(i_rgb[23:16]);
    o_rgb.g = quant(i_rgb[15:8]);
    o_rgb.b = quant(i_rgb[7:0]);
  end

endmodule

// File: rtl/ledpanel_fb_sched.sv
// Video-memory write scheduler: CPU/blitter round-robin arbitration, double-buffered
// page flip on frame boundaries, frame counter. Optional macro: LEDPANEL_GAMMA_EN.
module ledpanel_fb_sched
  import ledpanel_pkg::*;
#(
  parameter int unsigned PIX_AW     = LP_PIX_AW,
  parameter int unsigned FRAMECNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_wr,
  input  logic              ctrl_rd,
  input  logic [15:0]       ctrl_addr,
  input  logic [31:0]       ctrl_wdat,
  output logic [31:0]       ctrl_rdat,
  output logic              ctrl_done,
  input  logic              bl_valid,
  output logic              bl_ready,
  input  logic [PIX_AW-1:0] bl_addr,
  input  logic [23:0]       bl_rgb,
  input  logic              frame_start,
  output logic              vm_we,
  output logic [PIX_AW:0]   vm_addr,
  output logic [11:0]       vm_rgb,
  output logic              scan_page
);

  logic                  r_vm_we;
  logic [PIX_AW:0]       r_vm_addr;
  lp_rgb444_t            r_vm_rgb;
  logic                  r_ctrl_done;
  logic [31:0]           r_ctrl_rdat;
  logic                  r_scan_page;
  logic                  r_flip_pending;
  logic [FRAMECNT_W-1:0] r_framecnt;
  lp_gnt_e               r_last_grant;
  lp_gnt_e               w_next_grant;

  logic                  w_is_pix;
  logic                  w_a_req;
  logic                  w_reg_req;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_flip_req;
  logic [PIX_AW-1:0]     w_pix_idx;
  logic [23:0]           w_rgb24;
  lp_rgb444_t            w_q;
  logic [31:0]           w_rdat;
  logic                  w_unused;

  // The done pulse masks the still-held request so it is not serviced twice.
  assign w_is_pix  = ctrl_wr && (ctrl_addr[15:12] == 4'h0);
  assign w_a_req   = w_is_pix && !r_ctrl_done;
  assign w_reg_req = (ctrl_wr || ctrl_rd) && !w_is_pix && !r_ctrl_done;
  assign w_flip_req = w_reg_req && ctrl_wr && (ctrl_addr == LP_CTRL_ADDR) && ctrl_wdat[0];
  assign w_unused  = ^ctrl_wdat[31:24];

  always_comb begin
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_next_grant = r_last_grant;
    if (w_a_req && (!bl_valid || r_last_grant == LP_GNT_BLIT)) begin
      w_gnt_a      = 1'b1;
      w_next_grant = LP_GNT_CPU;
    end else if (bl_valid) begin
      w_gnt_b      = 1'b1;
      w_next_grant = LP_GNT_BLIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_last_grant <= LP_GNT_BLIT;
    else       r_last_grant <= w_next_grant;
  end

  assign bl_ready  = w_gnt_b;
  assign w_pix_idx = w_gnt_a ? ctrl_addr[PIX_AW+1:2] : bl_addr;
  assign w_rgb24   = w_gnt_a ? ctrl_wdat[23:0] : bl_rgb;

  ledpanel_rgb_quant u_quant (
    .i_rgb (w_rgb24),
    .o_rgb (w_q)
  );

  always_comb begin
    w_rdat = '0;
    if (w_reg_req && ctrl_rd && !ctrl_wr) begin
      if (ctrl_addr == LP_CTRL_ADDR)
        w_rdat = {30'b0, r_flip_pending, r_scan_page};
      else if (ctrl_addr == LP_FRAMECNT_ADDR)
        w_rdat = 32'(r_framecnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vm_we        <= 1'b0;
      r_vm_addr      <= '0;
      r_vm_rgb       <= '0;
      r_ctrl_done    <= 1'b0;
      r_ctrl_rdat    <= '0;
      r_scan_page    <= 1'b0;
      r_flip_pending <= 1'b0;
      r_framecnt     <= '0;
    end else begin
      r_vm_we <= w_gnt_a | w_gnt_b;
      if (w_gnt_a || w_gnt_b) begin
        r_vm_addr <= {~r_scan_page, w_pix_idx};
        r_vm_rgb  <= w_q;
      end
      r_ctrl_done <= w_gnt_a | w_reg_req;
      r_ctrl_rdat <= w_rdat;
      if (frame_start) r_framecnt <= r_framecnt + 1'b1;
      // A flip only takes effect on a boundary where it was already pending.
      if (frame_start && r_flip_pending) begin
        r_scan_page    <= ~r_scan_page;
        r_flip_pending <= 1'b0;
      end else if (w_flip_req) begin
        r_flip_pending <= 1'b1;
      end
    end
  end

  assign vm_we     = r_vm_we;
  assign vm_addr   = r_vm_addr;
  assign vm_rgb    = r_vm_rgb;
  assign ctrl_done = r_ctrl_done;
  assign ctrl_rdat = r_ctrl_rdat;
  assign scan_page = r_scan_page;

endmodule

// File: tb/tb_ledpanel_fb_sched.sv
// Scoreboard bench for ledpanel_fb_sched: stimulus pushes expected write/done events.
module tb_ledpanel_fb_sched;

  logic        clk;
  logic        reset;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;
  logic        bl_valid;
  logic        bl_ready;
  logic [9:0]  bl_addr;
  logic [23:0] bl_rgb;
  logic        frame_start;
  logic        vm_we;
  logic [10:0] vm_addr;
  logic [11:0] vm_rgb;
  logic        scan_page;

  ledpanel_fb_sched #(.PIX_AW(10), .FRAMECNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_wr     (ctrl_wr),
    .ctrl_rd     (ctrl_rd),
    .ctrl_addr   (ctrl_addr),
    .ctrl_wdat   (ctrl_wdat),
    .ctrl_rdat   (ctrl_rdat),
    .ctrl_done   (ctrl_done),
    .bl_valid    (bl_valid),
    .bl_ready    (bl_ready),
    .bl_addr     (bl_addr),
    .bl_rgb      (bl_rgb),
    .frame_start (frame_start),
    .vm_we       (vm_we),
    .vm_addr     (vm_addr),
    .vm_rgb      (vm_rgb),
    .scan_page   (scan_page)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        we;
    logic [10:0] addr;
    logic [11:0] rgb;
    logic        done;
    logic [31:0] rdat;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

`ifdef LEDPANEL_GAMMA_EN
  localparam logic [11:0] QUANT_804020 = 12'h410;
`else
  localparam logic [11:0] QUANT_804020 = 12'h842;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push(input string n, input logic we, input logic [10:0] a, input logic [11:0] c,
                      input logic done, input logic rd, input logic [31:0] d);
    ev_t e;
    e.rd   = rd;
    e.we   = we;
    e.addr = we ? a : 11'd0;
    e.rgb  = we ? c : 12'd0;
    e.done = done;
    e.rdat = rd ? d : 32'd0;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  ev_t   mon_e;
  ev_t   mon_a;
  string mon_n;
  always @(negedge clk) begin
    if (!reset && (vm_we || ctrl_done)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: vm_we=%b vm_addr=%h vm_rgb=%h ctrl_done=%b, required none",
                 vm_we, vm_addr, vm_rgb, ctrl_done);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        mon_a.rd   = mon_e.rd;
        mon_a.we   = vm_we;
        mon_a.addr = vm_we ? vm_addr : 11'd0;
        mon_a.rgb  = vm_we ? vm_rgb : 12'd0;
        mon_a.done = ctrl_done;
        mon_a.rdat = (mon_e.rd && ctrl_done) ? ctrl_rdat : 32'd0;
        check(mon_n, 64'(mon_a), 64'(mon_e));
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic cpu_acc(input logic wr, input logic [15:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    ctrl_wr = wr; ctrl_rd = !wr; ctrl_addr = a; ctrl_wdat = d;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (ctrl_done) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ctrl_wr = 1'b0; ctrl_rd = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL ctrl_done_timeout: addr=%h actual=no done required=done", a);
    end
  endtask

  task automatic blit(input logic [9:0] a, input logic [23:0] c);
    bit ok;
    ok = 0;
    bl_valid = 1'b1; bl_addr = a; bl_rgb = c;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bl_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bl_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL bl_ready_timeout: idx=%0d actual=no grant required=grant", a);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_wr = 0; ctrl_rd = 0; ctrl_addr = '0; ctrl_wdat = '0;
    bl_valid = 0; bl_addr = '0; bl_rgb = '0; frame_start = 0; reset = 0;
    do_reset();

    @(negedge clk);
    check("rst_vm_we", vm_we, 0);
    check("rst_vm_addr", vm_addr, 0);
    check("rst_vm_rgb", vm_rgb, 0);
    check("rst_ctrl_done", ctrl_done, 0);
    check("rst_ctrl_rdat", ctrl_rdat, 0);
    check("rst_scan_page", scan_page, 0);
    check("rst_bl_ready", bl_ready, 0);
    @(posedge clk); #1;

    push("t1_cpu_pix", 1, {1'b1, 10'd2}, 12'hF81, 1, 0, 0);
    cpu_acc(1, 16'h0008, 32'h00FF8010);

    push("t6_blit_quant", 1, {1'b1, 10'd5}, QUANT_804020, 0, 0, 0);
    blit(10'd5, 24'h804020);

    // Contention: CPU first (last grant was blitter), then strict alternation.
    push("t2_cpu_a1", 1, {1'b1, 10'd4},    12'h135, 1, 0, 0);
    push("t2_blit_b0", 1, {1'b1, 10'd7},   12'hACE, 0, 0, 0);
    push("t2_cpu_a2", 1, {1'b1, 10'd1023}, 12'h0F0, 1, 0, 0);
    push("t2_blit_b1", 1, {1'b1, 10'd0},   12'h012, 0, 0, 0);
    fork
      begin
        cpu_acc(1, 16'h0010, 32'h00123456);
        cpu_acc(1, 16'h0FFC, 32'hFF00FF00);
      end
      begin
        blit(10'd7, 24'hABCDEF);
        blit(10'd0, 24'h0F1F2F);
      end
      begin
        @(negedge clk);
        check("t2_bl_ready_cpu_gnt", bl_ready, 0);
      end
    join

    push("t3_flip_wr", 0, 0, 0, 1, 0, 0);
    cpu_acc(1, 16'h1000, 32'h1);
    push("t3_ctrl_rd_pending", 0, 0, 0, 1, 1, 32'h2);
    cpu_acc(0, 16'h1000, 0);
    frame_start = 1'b1;
    @(negedge clk);
    check("t3_scan_in_pulse", scan_page, 0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    check("t3_scan_after_pulse", scan_page, 1);
    @(posedge clk); #1;
    push("t3_ctrl_rd_flipped", 0, 0, 0, 1, 1, 32'h1);
    cpu_acc(0, 16'h1000, 0);
    push("t3_pix_page0", 1, {1'b0, 10'd1}, 12'h123, 1, 0, 0);
    cpu_acc(1, 16'h0004, 32'h00102030);

    push("t4_flip_wr_coinc", 0, 0, 0, 1, 0, 0);
    fork
      cpu_acc(1, 16'h1000, 32'h1);
      pulse_frame();
    join
    @(negedge clk);
    check("t4_scan_unchanged", scan_page, 1);
    @(posedge clk); #1;
    push("t4_ctrl_rd_pending", 0, 0, 0, 1, 1, 32'h3);
    cpu_acc(0, 16'h1000, 0);
    push("t4_blit_preflip_page", 1, {1'b0, 10'd9}, 12'h9AB, 0, 0, 0);
    fork
      blit(10'd9, 24'h90A0B0);
      pulse_frame();
    join
    @(negedge clk);
    check("t4_scan_flipped", scan_page, 0);
    @(posedge clk); #1;
    push("t4_ctrl_rd_done", 0, 0, 0, 1, 1, 32'h0);
    cpu_acc(0, 16'h1000, 0);

    do_reset();
    frame_start = 1'b1;
    repeat (65537) @(posedge clk);
    #1 frame_start = 1'b0;
    push("t5_framecnt_wrap", 0, 0, 0, 1, 1, 32'h1);
    cpu_acc(0, 16'h1004, 0);
    push("t5_unmapped_rd", 0, 0, 0, 1, 1, 32'h0);
    cpu_acc(0, 16'h2000, 0);
    push("t5_framecnt_wr", 0, 0, 0, 1, 0, 0);
    cpu_acc(1, 16'h1004, 32'h0000_5555);
    push("t5_framecnt_ro", 0, 0, 0, 1, 1, 32'h1);
    cpu_acc(0, 16'h1004, 0);

    push("t5_flip_wr", 0, 0, 0, 1, 0, 0);
    cpu_acc(1, 16'h1000, 32'h1);
    pulse_frame();
    @(negedge clk);
    check("t5_scan_before_reset", scan_page, 1);
    @(posedge clk); #1;
    bl_valid = 1'b1; bl_addr = 10'd3; bl_rgb = 24'hFFFFFF; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_rst_vm_we", vm_we, 0);
    check("t5_rst_scan_page", scan_page, 0);
    check("t5_rst_ctrl_done", ctrl_done, 0);
    @(posedge clk); #1;
    reset = 1'b0; bl_valid = 1'b0;
    @(negedge clk);
    check("t5_post_rst_vm_we", vm_we, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
